mac_acc: RTL and testbench
==========================

# mac_acc

Accumulation stage directly downstream of the MAC top. It consumes the per-cycle `2*DW+1`-bit signed product stream over a valid/ready handshake and sums `cfg_len` consecutive products into one dot-product result. It presents each result on a registered valid/ready output port. The accumulator keeps running while a finished result waits for the consumer; it stalls only when a second result would overwrite one that has not yet been taken.

## Interface
- `DW`, 8: operand width of the upstream multiplier; product width is `PW = 2*DW+1`.
- `AW`, 24: accumulator and result width; must be ≥ `PW`.
- `MAX_LEN`, 256: maximum vector length; `LW = $clog2(MAX_LEN+1)`.

Ports:
- `clk` in 1: the single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_q` in PW: product, two's complement, sign-extended to `AW` internally.
- `cfg_len` in LW: vector length, sampled on the first beat of each vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_acc` out AW: dot-product result, signed.
- `out_ovf` out 1: overflow occurred somewhere in this vector.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- The FSM is in `mac_pkg::acc_state_e`:
  - `IDLE`: no vector open.
  - `ACCUM`: vector open, `cnt` beats taken.
- `IDLE`, accepted beat:
  - `len_q <= (cfg_len==0) ? 1 : min(cfg_len, MAX_LEN)`.
  - `acc <= sext(in_q)`, `cnt <= 1`, `ovf <= 0`.
  - If `len_q` is 1, the beat is also the last beat.
  - Otherwise go to `ACCUM`.
- `ACCUM`, accepted beat: `acc <= acc + sext(in_q)` and `cnt++`.
- Last beat (`cnt+1 == len_q`, or the length-1 case):
  - `out_acc <= final sum`, `out_ovf <= ovf | this-beat overflow`, `out_valid <= 1`.
  - FSM goes to `IDLE`.
- Addition is `AW+1`-bit. Overflow means the carry/sign bits disagree.
- `out_valid` clears on `out_valid && out_ready`, unless a new result loads in the same cycle; then it stays 1 with the new data.
- `in_ready = !(out_valid && !out_ready && beat_is_last)`.
  - Non-last beats are never stalled.
  - A last beat is accepted in the same cycle the pending result is consumed.
- `cfg_len` is ignored except on the first beat of a vector.
- The `in_q` value is a don't-care when `in_valid` is 0.

## Timing
- Latency: result appears in `out_acc` / `out_valid` one cycle after the last beat is accepted.
- Throughput: one beat per cycle. Back-to-back vectors need no bubble.
- Reset values: `out_valid=0`, `out_acc=0`, `out_ovf=0`, FSM `IDLE`, `cnt=0`, `acc=0`.
  - `in_ready` is 1 out of reset, since `out_valid=0`.
- Reset mid-vector discards the partial sum and any pending result. No output is produced for them.
- Once `out_valid` is high, `out_acc` and `out_ovf` hold stable until the handshake completes.

## Configuration
- `MAC_ACC_SAT_EN` defined:
  - On overflow, the accumulator clamps to `2^(AW-1)-1` or `-2^(AW-1)` according to the sign of the true sum.
  - Later beats continue from the clamped value.
- Undefined: two's-complement wrap-around at `AW` bits.
- `out_ovf` is reported identically in both builds.

## Structure
- Package `mac_pkg`:
  - `acc_state_e` enum.
  - `ACC_MAX(AW)` / `ACC_MIN(AW)` constant functions.
  - The `PW` derivation function.
  - Shared with other MAC stages.
- Sub-module `mac_acc_add`: combinational `AW`-bit signed adder.
  - Outputs the sum and an overflow flag.
  - Contains the `MAC_ACC_SAT_EN` clamp.
- The FSM, counter and output register live in `mac_acc`.

## Test plan
All scenarios use `DW=8`, `AW=24`.
- **Basic sum:** `cfg_len=4`, products 1,2,3,4 streamed, `out_ready=1` → `out_acc=10`, `out_ovf=0`, `out_valid` pulses once, one cycle after the 4th beat.
- **Signed and length clamp:**
  - `cfg_len=3`, products −65280, 65025, −1 → `out_acc=−256`.
  - Then `cfg_len=0`, product 7 → `out_acc=7` (length treated as 1).
- **Overflow:** `cfg_len=130`, all products 65025.
  - With `MAC_ACC_SAT_EN`: `out_acc=8388607`, `out_ovf=1`.
  - Without: `out_acc=−8323966`, `out_ovf=1`.
- **Backpressure:**
  - Hold `out_ready=0`; run two `cfg_len=2` vectors {5,5} and {1,1} back-to-back.
  - Expect `in_ready=0` on the 2nd vector's last beat; `out_acc` stays 10.
  - Raise `out_ready`: the last beat is accepted that cycle, and `out_acc=2` appears the next cycle.
- **Reset mid-operation:** assert `rst_n=0` after 2 of 4 beats → all outputs reset. Then `cfg_len=1`, product 9 → `out_acc=9` with no stale data.
- **Back-to-back throughput:** 8 vectors of `cfg_len=2`, `in_valid` held high, `out_ready=1` → 8 results, `in_ready` never deasserted.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared MAC-stage types and constant helpers.
package mac_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    function automatic int mac_pw(input int dw);
        return 2 * dw + 1;
    endfunction

    function automatic longint ACC_MAX(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic longint ACC_MIN(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

endpackage

// File: rtl/mac_acc_if.sv
// Product-in / result-out handshake bundle for the MAC accumulation stage.
interface mac_acc_if #(
    parameter int DW      = 8,
    parameter int AW      = 24,
    parameter int MAX_LEN = 256
);
    localparam int PW = mac_pkg::mac_pw(DW);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_q;
    logic [LW-1:0] cfg_len;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_acc;
    logic          out_ovf;

    modport master (
        output in_valid, in_q, cfg_len, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_q, cfg_len, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/mac_acc_add.sv
// AW-bit signed adder with overflow flag; MAC_ACC_SAT_EN selects clamping instead of wrap.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);
    logic [AW:0] wide;

    // One guard bit: the true sign sits in wide[AW], so overflow is the two top bits disagreeing.
    assign wide = {a[AW-1], a} + {b[AW-1], b};
    assign ovf  = wide[AW] ^ wide[AW-1];

`ifdef MAC_ACC_SAT_EN
    localparam logic [AW-1:0] SAT_MAX = AW'(ACC_MAX(AW));
    localparam logic [AW-1:0] SAT_MIN = AW'(ACC_MIN(AW));

    assign sum = ovf ? (wide[AW] ? SAT_MIN : SAT_MAX) : wide[AW-1:0];
`else
    assign sum = wide[AW-1:0];
`endif

endmodule

// File: rtl/mac_acc.sv
// Dot-product accumulator: sums cfg_len products per vector, registered result port.
// Build option MAC_ACC_SAT_EN (in mac_acc_add) clamps instead of wrapping on overflow.
module mac_acc
    import mac_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 24,
    parameter int MAX_LEN = 256
) (
    input logic    clk,
    input logic    rst_n,
    mac_acc_if.slave bus
);
    localparam int PW = mac_pw(DW);
    localparam int LW = $clog2(MAX_LEN + 1);

    acc_state_e    state_q, state_d;
    logic [AW-1:0] acc_q, base, in_ext, sum;
    logic [LW-1:0] cnt_q, len_q, len_first;
    logic          ovf_q, add_ovf, ovf_run;
    logic          beat_is_last, accept, load;
    logic          out_valid_q, out_ovf_q;
    logic [AW-1:0] out_acc_q;

    always_comb begin
        len_first = bus.cfg_len;
        if (bus.cfg_len == '0)
            len_first = LW'(1);
        else if (bus.cfg_len > LW'(MAX_LEN))
            len_first = LW'(MAX_LEN);
    end

    assign in_ext       = AW'($signed(bus.in_q[PW-1:0]));
    assign base         = (state_q == IDLE) ? '0 : acc_q;
    assign beat_is_last = (state_q == IDLE) ? (len_first == LW'(1))
                                            : (cnt_q + LW'(1) == len_q);
    assign ovf_run      = ((state_q == ACCUM) && ovf_q) | add_ovf;

    mac_acc_add #(.AW(AW)) u_add (
        .a   (base),
        .b   (in_ext),
        .sum (sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = beat_is_last ? IDLE : ACCUM;
    end

    // Only a last beat can collide with an untaken result; everything else flows.
    always_comb begin
        bus.in_ready = !(out_valid_q && !bus.out_ready && beat_is_last);
        accept       = bus.in_valid && bus.in_ready;
        load         = accept && beat_is_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            acc_q <= sum;
            ovf_q <= ovf_run;
            if (state_q == IDLE) begin
                len_q <= len_first;
                cnt_q <= LW'(1);
            end else begin
                cnt_q <= cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= sum;
            out_ovf_q   <= ovf_run;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_acc.sv
// Scoreboard bench for mac_acc: directed vectors push expected results, a monitor checks handshakes.
module tb_mac_acc;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int MAX_LEN = 256;

    typedef struct {
        longint acc;
        longint ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passes = 0;
    int stalls = 0;
    exp_t exp_q[$];

    mac_acc_if #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) bus ();

    mac_acc #(.DW(DW), .AW(AW), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp)
            passes++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic expect_res(input longint acc, input longint ovf);
        exp_t e;
        e.acc = acc;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Presents one beat and returns just after the edge that accepted it.
    task automatic beat(input longint q, input int len);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_q     = 17'(q);
        bus.cfg_len  = 9'(len);
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        stalls += n;
        if (n >= 50) chk("beat_accept_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got acc %0d with empty scoreboard", $signed(bus.out_acc));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_acc", longint'($signed(bus.out_acc)), e.acc);
                chk("result_ovf", longint'(bus.out_ovf), e.ovf);
            end
        end
    end

    initial begin
        int st;
        int t;
        bus.in_valid  = 1'b0;
        bus.in_q      = '0;
        bus.cfg_len   = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        chk("reset_out_valid", longint'(bus.out_valid), 0);
        chk("reset_out_acc", longint'(bus.out_acc), 0);
        chk("reset_out_ovf", longint'(bus.out_ovf), 0);
        chk("reset_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic sum, with latency and single-pulse check
        expect_res(10, 0);
        beat(1, 4); beat(2, 4); beat(3, 4);
        beat(4, 4);
        @(negedge clk);
        chk("basic_latency_valid", longint'(bus.out_valid), 1);
        chk("basic_latency_acc", longint'($signed(bus.out_acc)), 10);
        @(negedge clk);
        chk("basic_pulse_once", longint'(bus.out_valid), 0);
        @(posedge clk); #1;

        // Signed sum; cfg_len on non-first beats must be ignored
        expect_res(-256, 0);
        beat(-65280, 3); beat(65025, 1); beat(-1, 0);
        expect_res(7, 0);
        beat(7, 0);

        // Length above MAX_LEN clamps to MAX_LEN
        expect_res(256, 0);
        for (int i = 0; i < 256; i++) beat(1, (i == 0) ? 511 : 0);
        expect_res(3, 0);
        beat(3, 1);

        // Overflow
`ifdef MAC_ACC_SAT_EN
        expect_res(8388607, 1);
`else
        expect_res(-8323966, 1);
`endif
        for (int i = 0; i < 130; i++) beat(65025, 130);

        // Backpressure
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        expect_res(10, 0);
        expect_res(2, 0);
        beat(5, 2); beat(5, 2);
        beat(1, 2);
        bus.in_valid = 1'b1;
        bus.in_q     = 17'd1;
        bus.cfg_len  = 9'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", longint'(bus.in_ready), 0);
            chk("bp_out_valid_held", longint'(bus.out_valid), 1);
            chk("bp_out_acc_held", longint'($signed(bus.out_acc)), 10);
            @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_in_ready_on_consume", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_new_result_valid", longint'(bus.out_valid), 1);
        chk("bp_new_result_acc", longint'($signed(bus.out_acc)), 2);
        @(posedge clk); #1;

        // Reset mid-vector
        beat(1, 4); beat(2, 4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_out_acc", longint'(bus.out_acc), 0);
        chk("midrst_out_ovf", longint'(bus.out_ovf), 0);
        chk("midrst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_res(9, 0);
        beat(9, 1);

        // Back-to-back throughput
        st = stalls;
        for (int k = 0; k < 8; k++) begin
            expect_res(2 * k + 1, 0);
            beat(k, 2);
            beat(k + 1, 2);
        end
        chk("b2b_no_stall", stalls - st, 0);

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
